// File: rtl/multi_voice_sound_gen.sv
// Multi-voice pulse/noise sample generator.
// Each voice owns its registers, period counter, duty counter, LFSR and flag.
// The top visits one voice per clk after sample_tick and emits one saturated,
// shifted, signed sample per sweep.

module mvsg_voice #(
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 5,
  parameter bit RST_EN   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_sel,
  input  logic [1:0]          wr_reg,
  input  logic [PERIOD_W-1:0] wr_data,
  output logic signed [VOL_W:0] contrib
);
  logic [PERIOD_W-1:0] period, counter;
  logic [VOL_W-1:0]    volume;
  logic [2:0]          mode, pulse_ctr;
  logic                enable, flag;
  logic [15:0]         lfsr;
  logic signed [VOL_W:0] vol_s;

  // Register file; a write lands one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= PERIOD_W'(14205);
      volume <= VOL_W'(8);
      mode   <= 3'd3;
      enable <= RST_EN;
    end else if (wr_sel) begin
      case (wr_reg)
        2'd0:    period <= wr_data;
        2'd1:    volume <= wr_data[VOL_W-1:0];
        2'd2:    mode   <= wr_data[2:0];
        default: enable <= wr_data[0];
      endcase
    end
  end

  // Tone/noise stepping and flag; sees pre-write register values, frozen when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= PERIOD_W'(1);
      pulse_ctr <= 3'd0;
      lfsr      <= 16'hFFFF;
      flag      <= 1'b0;
    end else if (enable) begin
      flag <= mode[2] ? lfsr[0] : (pulse_ctr <= {1'b0, mode[1:0]});
      if (counter >= period) begin
        counter   <= PERIOD_W'(1);
        pulse_ctr <= pulse_ctr + 3'd1;   // 7 wraps to 0
        lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end else begin
        counter <= counter + PERIOD_W'(1);
      end
    end else begin
      flag <= 1'b0;
    end
  end

  assign vol_s   = $signed({1'b0, volume});
  assign contrib = !enable ? '0 : (flag ? vol_s : -vol_s);
endmodule

module multi_voice_sound_gen #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 16,
  parameter int VOL_W      = 5,
  parameter int SAMPLE_W   = 24,
  parameter int SHIFT      = 11,
  localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [VIDX_W-1:0]   wr_voice,
  input  logic [1:0]          wr_reg,
  input  logic [PERIOD_W-1:0] wr_data,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy
);
  // acc holds at most NUM_VOICES * (2^VOL_W - 1) in magnitude, so it never wraps
  localparam int ACC_W = VOL_W + VIDX_W + 1;
  localparam int WW    = ((ACC_W + SHIFT) > SAMPLE_W ? (ACC_W + SHIFT) : SAMPLE_W) + 1;
  localparam logic signed [WW-1:0] SMAX = {{(WW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  logic [NUM_VOICES-1:0][VOL_W:0] contrib;
  state_t                 state, state_nx;
  logic [VIDX_W-1:0]      idx;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic signed [VOL_W:0]  cur;
  logic signed [WW-1:0]   wide;
  logic [SAMPLE_W-1:0]    sat;
  logic                   last;

  // Voice array; out-of-range wr_voice matches no instance and is dropped
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    mvsg_voice #(
      .PERIOD_W(PERIOD_W),
      .VOL_W   (VOL_W),
      .RST_EN  (i == 0)
    ) u_voice (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_sel (wr_en && (wr_voice == VIDX_W'(i))),
      .wr_reg (wr_reg),
      .wr_data(wr_data),
      .contrib(contrib[i])
    );
  end

  assign cur     = contrib[idx];
  assign acc_sum = acc + ACC_W'(cur);
  assign last    = (idx == VIDX_W'(NUM_VOICES - 1));
  assign wide    = WW'(acc_sum) <<< SHIFT;

  // Clamp the shifted final sum into the signed output range
  always_comb begin
    sat = wide[SAMPLE_W-1:0];
    if (wide > SMAX)      sat = SMAX[SAMPLE_W-1:0];
    else if (wide < SMIN) sat = SMIN[SAMPLE_W-1:0];
  end

  // Mixer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Mixer next state; ticks outside IDLE are dropped
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_tick) state_nx = SUM;
      SUM:     if (last) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator, voice index and output sample; sample lands as OUT is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      idx    <= '0;
      sample <= '0;
    end else begin
      case (state)
        IDLE: if (sample_tick) begin
          acc <= '0;
          idx <= '0;
        end
        SUM: begin
          acc <= acc_sum;
          idx <= idx + VIDX_W'(1);
          if (last) sample <= sat;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign sample_valid = (state == OUT);
endmodule
